// File: rtl/sme_job_sequencer.sv
// -----------------------------------------------------------------------------
// sme_job_sequencer
//
// Host-side controller for the string matching engine. Buffers one job (one
// string plus up to NPAT patterns) from a valid/ready byte stream, replays it
// to the engine one pattern per match run, and hands back one result per
// pattern over a valid/ready result port. The engine keeps its string between
// runs, so the string is only sent before the first pattern of a job.
//
// Optional feature macro: SME_SEQ_TIMEOUT_EN
//   defined   : watchdog in WAIT_RES; after TIMEOUT silent cycles a result with
//               o_res_timeout=1, match=0, index=0 is produced.
//   undefined : WAIT_RES waits indefinitely; o_res_timeout is always 0.
//
// Ports
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_in_valid / o_in_ready           host char handshake (ready only in LOAD)
//   i_in_data, i_in_str               char and string(1)/pattern(0) select
//   i_in_last, i_in_eoj               end of pattern / end of job markers
//   o_sme_chardata                    char to engine (0 when no strobe)
//   o_sme_isstring, o_sme_ispattern   engine char strobes
//   i_sme_match, i_sme_match_index    engine result, qualified by i_sme_valid
//   o_res_valid / i_res_ready         result handshake
//   o_res_match, o_res_index          captured engine result
//   o_res_pat_id                      pattern number within the job
//   o_res_timeout                     result came from the watchdog
//   o_job_done                        pulse after the last result is taken
//   o_err_ovf                         sticky overflow, cleared by next job
// -----------------------------------------------------------------------------
module sme_job_sequencer #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int NPAT    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [7:0]               i_in_data,
  input  logic                     i_in_str,
  input  logic                     i_in_last,
  input  logic                     i_in_eoj,
  output logic [7:0]               o_sme_chardata,
  output logic                     o_sme_isstring,
  output logic                     o_sme_ispattern,
  input  logic                     i_sme_match,
  input  logic [4:0]               i_sme_match_index,
  input  logic                     i_sme_valid,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic                     o_res_match,
  output logic [4:0]               o_res_index,
  output logic [$clog2(NPAT)-1:0]  o_res_pat_id,
  output logic                     o_res_timeout,
  output logic                     o_job_done,
  output logic                     o_err_ovf
);

  localparam int SAW = $clog2(STR_MAX);
  localparam int SCW = SAW + 1;
  localparam int CAW = $clog2(PAT_MAX);
  localparam int CCW = CAW + 1;
  localparam int PW  = $clog2(NPAT);
  localparam int PCW = PW + 1;
  localparam int IW  = (SCW > CCW) ? SCW : CCW;

  localparam logic [SCW-1:0] STR_FULL  = SCW'(STR_MAX);
  localparam logic [CCW-1:0] PAT_FULL  = CCW'(PAT_MAX);
  localparam logic [PCW-1:0] NPAT_FULL = PCW'(NPAT);

  typedef enum logic [2:0] {
    S_LOAD, S_SEND_STR, S_SEND_PAT, S_WAIT_RES, S_PUSH_RES
  } state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]     r_str_buf [STR_MAX];
  logic [7:0]     r_pat_buf [NPAT][PAT_MAX];
  logic [CCW-1:0] r_len     [NPAT];

  logic [SCW-1:0] r_str_cnt;
  logic [CCW-1:0] r_chr_cnt;
  logic [PCW-1:0] r_pat_cnt;
  logic [IW-1:0]  r_idx;
  logic [PW-1:0]  r_p;
  logic           r_res_match;
  logic [4:0]     r_res_index;
  logic           r_res_timeout;
  logic           r_job_done;
  logic           r_err_ovf;

  logic           w_accept, w_eoj, w_job_empty, w_more;
  logic           w_str_wr, w_pat_wr, w_len_wr, w_timeout;
  logic           w_str_last, w_pat_last;
  logic [IW-1:0]  w_idx_inc;
  logic [CCW-1:0] w_len_val;

  assign w_accept    = i_in_valid && (r_state == S_LOAD);
  assign w_eoj       = w_accept && !i_in_str && i_in_last && i_in_eoj;
  assign w_job_empty = (r_str_cnt == '0) && (r_pat_cnt == '0) && (r_chr_cnt == '0);
  assign w_more      = ({1'b0, r_p} + PCW'(1)) < r_pat_cnt;

  assign w_str_wr = w_accept && i_in_str && (r_str_cnt < STR_FULL);
  assign w_pat_wr = w_accept && !i_in_str && (r_pat_cnt < NPAT_FULL) && (r_chr_cnt < PAT_FULL);
  assign w_len_wr = w_accept && !i_in_str && i_in_last && (r_pat_cnt < NPAT_FULL);
  // Length includes the in_last char itself unless it was dropped by overflow.
  assign w_len_val = (r_chr_cnt < PAT_FULL) ? r_chr_cnt + CCW'(1) : r_chr_cnt;

  assign w_idx_inc  = r_idx + IW'(1);
  assign w_str_last = (w_idx_inc == IW'(r_str_cnt));
  assign w_pat_last = (w_idx_inc == IW'(r_len[r_p]));

`ifdef SME_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wd;

  // Counter is 0 on the first WAIT_RES cycle; firing on TIMEOUT-1 puts
  // res_valid TIMEOUT+1 cycles after the last pattern strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state != S_WAIT_RES)) r_wd <= '0;
    else                                     r_wd <= r_wd + TW'(1);
  end
  assign w_timeout = (r_state == S_WAIT_RES) && (r_wd == TW'(TIMEOUT - 1));
`else
  // Watchdog compiled out; TIMEOUT has no effect in this build.
  assign w_timeout = (TIMEOUT < 0);
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_LOAD;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    o_in_ready      = 1'b0;
    o_sme_isstring  = 1'b0;
    o_sme_ispattern = 1'b0;
    o_sme_chardata  = 8'h00;
    o_res_valid     = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        o_in_ready = 1'b1;
        if (w_eoj) w_state_nxt = (r_str_cnt != '0) ? S_SEND_STR : S_SEND_PAT;
      end
      S_SEND_STR: begin
        o_sme_isstring = 1'b1;
        o_sme_chardata = r_str_buf[r_idx[SAW-1:0]];
        if (w_str_last) w_state_nxt = S_SEND_PAT;
      end
      S_SEND_PAT: begin
        o_sme_ispattern = 1'b1;
        o_sme_chardata  = r_pat_buf[r_p][r_idx[CAW-1:0]];
        if (w_pat_last) w_state_nxt = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (i_sme_valid || w_timeout) w_state_nxt = S_PUSH_RES;
      end
      S_PUSH_RES: begin
        o_res_valid = 1'b1;
        if (i_res_ready) w_state_nxt = w_more ? S_SEND_PAT : S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // NOTE: char buffers are not reset; the counters alone define which entries
  // are valid, so clearing the counters empties the buffers.
  always_ff @(posedge i_clk) begin
    if (w_str_wr) r_str_buf[r_str_cnt[SAW-1:0]] <= i_in_data;
    if (w_pat_wr) r_pat_buf[r_pat_cnt[PW-1:0]][r_chr_cnt[CAW-1:0]] <= i_in_data;
    if (w_len_wr) r_len[r_pat_cnt[PW-1:0]] <= w_len_val;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_str_cnt     <= '0;
      r_chr_cnt     <= '0;
      r_pat_cnt     <= '0;
      r_idx         <= '0;
      r_p           <= '0;
      r_res_match   <= 1'b0;
      r_res_index   <= '0;
      r_res_timeout <= 1'b0;
      r_job_done    <= 1'b0;
      r_err_ovf     <= 1'b0;
    end else begin
      r_job_done <= 1'b0;
      unique case (r_state)
        S_LOAD: if (w_accept) begin
          if (w_job_empty) r_err_ovf <= 1'b0;
          if (i_in_str) begin
            if (r_str_cnt < STR_FULL) r_str_cnt <= r_str_cnt + SCW'(1);
            else                      r_err_ovf <= 1'b1;
          end else if (r_pat_cnt < NPAT_FULL) begin
            if (r_chr_cnt < PAT_FULL) r_chr_cnt <= r_chr_cnt + CCW'(1);
            else                      r_err_ovf <= 1'b1;
            if (i_in_last) begin
              r_chr_cnt <= '0;
              r_pat_cnt <= r_pat_cnt + PCW'(1);
            end
          end else begin
            // Patterns beyond NPAT are swallowed whole; chr_cnt stays 0.
            r_err_ovf <= 1'b1;
          end
        end
        S_SEND_STR: r_idx <= w_str_last ? '0 : w_idx_inc;
        S_SEND_PAT: r_idx <= w_pat_last ? '0 : w_idx_inc;
        S_WAIT_RES: begin
          if (i_sme_valid) begin
            r_res_match   <= i_sme_match;
            r_res_index   <= i_sme_match_index;
            r_res_timeout <= 1'b0;
          end else if (w_timeout) begin
            r_res_match   <= 1'b0;
            r_res_index   <= '0;
            r_res_timeout <= 1'b1;
          end
        end
        S_PUSH_RES: if (i_res_ready) begin
          if (w_more) begin
            r_p <= r_p + PW'(1);
          end else begin
            r_job_done <= 1'b1;
            r_str_cnt  <= '0;
            r_chr_cnt  <= '0;
            r_pat_cnt  <= '0;
            r_p        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_res_match   = r_res_match;
  assign o_res_index   = r_res_index;
  assign o_res_pat_id  = r_p;
  assign o_res_timeout = r_res_timeout;
  assign o_job_done    = r_job_done;
  assign o_err_ovf     = r_err_ovf;

endmodule
